// File: rtl/mealy_fsm.sv
// mealy_fsm: serial-bit pattern detector (Mealy FSM with KMP fallback).
// Samples `in` every rising clk edge and raises `out` combinationally in
// the cycle the last pattern bit is present on `in`.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous reset, active low (0 = in reset)
//   in        - serial data bit
//   out       - match flag, combinational from state and `in`
//   match_cnt - saturating match counter (only with MEALY_CNT_EN)
//
// Optional feature macro: MEALY_CNT_EN adds the match_cnt port/counter.
//
// State k = length of the longest pattern prefix that is a suffix of the
// bits received so far. Mismatch targets come from a constant function
// evaluated at elaboration time.

module mealy_fsm #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out
`ifdef MEALY_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int SW   = $clog2(PATTERN_W);
    localparam int LAST = PATTERN_W - 1;

    if (PATTERN_W < 2 || PATTERN_W > 16 || CNT_W < 1) begin : g_bad_param
        $error("mealy_fsm: illegal PATTERN_W or CNT_W");
    end

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic bit pat_bit(input int i);
        return PATTERN[PATTERN_W-1-i];
    endfunction

    // Longest prefix (length <= max_len) of the pattern that is a suffix
    // of "first k pattern bits followed by b".
    function automatic int kmp_next(input int k, input bit b,
                                    input int max_len);
        int  res;
        int  j;
        bit  ok;
        bit  s;
        res = 0;
        for (int len = 1; len <= max_len; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                j = k + 1 - len + i;
                s = (j == k) ? b : pat_bit(j);
                if (s != pat_bit(i)) ok = 1'b0;
            end
            if (ok) res = len;
        end
        return res;
    endfunction

    // Longest proper border of the whole pattern: restart point after a
    // match when overlapping detection is enabled.
    localparam int BORDER = kmp_next(LAST, PATTERN[0], LAST);

    typedef enum logic [SW-1:0] {
        ST_EMPTY = SW'(0),
        ST_LAST  = SW'(LAST)
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   hit;

    // Expected bit and mismatch targets per state, fixed at elaboration.
    logic [PATTERN_W-1:0]         want_tbl;
    logic [PATTERN_W-1:0][SW-1:0] fall0_tbl;
    logic [PATTERN_W-1:0][SW-1:0] fall1_tbl;

    for (genvar gk = 0; gk < PATTERN_W; gk++) begin : g_tbl
        localparam int F0 = kmp_next(gk, 1'b0, gk);
        localparam int F1 = kmp_next(gk, 1'b1, gk);
        assign want_tbl[gk]  = PATTERN[PATTERN_W-1-gk];
        assign fall0_tbl[gk] = SW'(F0);
        assign fall1_tbl[gk] = SW'(F1);
    end

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (int'(state_q) > LAST) begin
            // Unreachable codes when PATTERN_W is not a power of two.
            state_d = ST_EMPTY;
        end else if (in == want_tbl[state_q]) begin
            if (state_q == ST_LAST) begin
                hit     = 1'b1;
                state_d = OVERLAP ? state_t'(SW'(BORDER)) : ST_EMPTY;
            end else begin
                state_d = state_t'(state_q + SW'(1));
            end
        end else begin
            state_d = state_t'(in ? fall1_tbl[state_q]
                                  : fall0_tbl[state_q]);
        end
    end

    // Gated by rst so the flag is low for the whole reset interval.
    assign out = rst & hit;

`ifdef MEALY_CNT_EN
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (out && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = match_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end
`endif

endmodule

// File: tb/tb_mealy_fsm.sv
// tb_mealy_fsm: self-checking bench for mealy_fsm.
// Three instances share clk/rst/in; a history-based model predicts out.

module tb_mealy_fsm;

    logic clk;
    logic rst;
    logic in;
    logic o_ovl;
    logic o_nov;
    logic o_k6;
    logic outs [3];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MEALY_CNT_EN
    logic [1:0] c_ovl;
    logic [1:0] c_nov;
    logic [2:0] c_k6;
    int         cnts [3];
    assign cnts[0] = int'(c_ovl);
    assign cnts[1] = int'(c_nov);
    assign cnts[2] = int'(c_k6);
`endif

    mealy_fsm #(
        .PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)
    ) u_ovl (
        .clk(clk), .rst(rst), .in(in), .out(o_ovl)
`ifdef MEALY_CNT_EN
        , .match_cnt(c_ovl)
`endif
    );

    mealy_fsm #(
        .PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(2)
    ) u_nov (
        .clk(clk), .rst(rst), .in(in), .out(o_nov)
`ifdef MEALY_CNT_EN
        , .match_cnt(c_nov)
`endif
    );

    mealy_fsm #(
        .PATTERN_W(6), .PATTERN(6'b101101), .OVERLAP(1'b1), .CNT_W(3)
    ) u_k6 (
        .clk(clk), .rst(rst), .in(in), .out(o_k6)
`ifdef MEALY_CNT_EN
        , .match_cnt(c_k6)
`endif
    );

    assign outs[0] = o_ovl;
    assign outs[1] = o_nov;
    assign outs[2] = o_k6;

    // Model: bits received since the last restart, newest in bit 0.
    int          pw   [3] = '{4, 4, 6};
    logic [15:0] pv   [3] = '{16'h000D, 16'h000D, 16'h002D};
    bit          ov   [3] = '{1'b1, 1'b0, 1'b1};
    int          cmax [3] = '{3, 3, 7};
    logic [15:0] hist [3];
    int          hn   [3];
    int          mcnt [3];
    bit          eo   [3];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit model_out(input int i, input logic b);
        logic [15:0] w;
        logic [15:0] mask;
        if (!rst) return 1'b0;
        w    = {hist[i][14:0], b};
        mask = 16'((32'd1 << pw[i]) - 1);
        return (hn[i] >= pw[i] - 1) && ((w & mask) == pv[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0;
            hn[i]   = 0;
            mcnt[i] = 0;
        end
    endtask

    // Drive a bit mid-cycle and check the combinational flag.
    task automatic eval(input logic b);
        in = b;
        #2;
        for (int i = 0; i < 3; i++) begin
            eo[i] = model_out(i, b);
            check($sformatf("out%0d", i), 32'(outs[i]), 32'(eo[i]));
        end
    endtask

    // Clock the bit in and advance the model.
    task automatic tick(input logic b);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                hist[i] = '0;
                hn[i]   = 0;
                mcnt[i] = 0;
            end else if (eo[i] && !ov[i]) begin
                if (mcnt[i] < cmax[i]) mcnt[i]++;
                hist[i] = '0;
                hn[i]   = 0;
            end else begin
                if (eo[i] && mcnt[i] < cmax[i]) mcnt[i]++;
                hist[i] = {hist[i][14:0], b};
                if (hn[i] < 16) hn[i]++;
            end
`ifdef MEALY_CNT_EN
            check($sformatf("cnt%0d", i), 32'(cnts[i]), 32'(mcnt[i]));
`endif
        end
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out%0d", i), 32'(outs[i]), 32'd0);
`ifdef MEALY_CNT_EN
            check($sformatf("rst_cnt%0d", i), 32'(cnts[i]), 32'd0);
`endif
        end
    endtask

    // One reset cycle then release, leaving all instances in state 0.
    task automatic pulse_rst();
        assert_rst();
        eval(1'b1);
        tick(1'b1);
        rst = 1'b1;
    endtask

    // Directed sequence; seq[0] is sent first, e0/e1 are the expected
    // flags of the overlapping / non-overlapping 1101 instances.
    task automatic run_seq(input logic [15:0] seq, input int len,
                           input logic [15:0] e0, input logic [15:0] e1);
        for (int j = 0; j < len; j++) begin
            eval(seq[j]);
            check($sformatf("seq_ovl[%0d]", j), 32'(o_ovl), 32'(e0[j]));
            check($sformatf("seq_nov[%0d]", j), 32'(o_nov), 32'(e1[j]));
            tick(seq[j]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        in    = 1'b0;
        rst   = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held for three cycles while in toggles.
        assert_rst();
        for (int j = 0; j < 3; j++) begin
            eval(j[0] ? 1'b0 : 1'b1);
            check("hold_rst", 32'(o_ovl), 32'd0);
            tick(j[0] ? 1'b0 : 1'b1);
        end
        rst = 1'b1;

        // Basic stream 0,1,1,0,1,1,1,0,1: matches on bits 5 and 9.
        run_seq(16'b101110110, 9, 16'b100010000, 16'b100010000);

        // Overlap stream 1,1,0,1,1,0,1.
        pulse_rst();
        run_seq(16'b1011011, 7, 16'b1001000, 16'b0001000);

        // Mid-pattern reset discards 1,1,0 progress.
        pulse_rst();
        run_seq(16'b011, 3, 16'b0, 16'b0);
        pulse_rst();
        run_seq(16'b10111, 5, 16'b10000, 16'b10000);

        // Mealy timing: sitting in S3, out follows in between edges.
        pulse_rst();
        run_seq(16'b011, 3, 16'b0, 16'b0);
        in = 1'b0;
        #1;
        check("mealy_lo", 32'(o_ovl), 32'd0);
        eval(1'b1);
        check("mealy_hi", 32'(o_ovl), 32'd1);
        tick(1'b1);

`ifdef MEALY_CNT_EN
        // 1101 five times back-to-back: counter saturates at 3.
        pulse_rst();
        for (int k = 1; k <= 5; k++) begin
            run_seq(16'b1011, 4, 16'b1000, 16'b1000);
            check($sformatf("sat_cnt%0d", k), 32'(c_ovl),
                  32'(k < 3 ? k : 3));
        end
        assert_rst();
        check("cnt_clr", 32'(c_ovl), 32'd0);
        rst = 1'b1;
`endif

        // Random stream with occasional reset pulses.
        pulse_rst();
        for (int j = 0; j < 1500; j++) begin
            logic b;
            if ($urandom_range(0, 79) == 0) begin
                pulse_rst();
            end else begin
                b = 1'($urandom_range(0, 1));
                eval(b);
                tick(b);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mealy_fsm.md
Name: mealy_fsm

Overview:
- Serial-bit pattern detector built as a Mealy finite state machine.
- Samples one input bit per clock and raises a combinational output in the same cycle that the final bit of a programmed pattern arrives.
- Used as a leaf block wherever a serial stream must be scanned for a fixed sync/marker word.
- Default pattern is 1101, first-received bit first.

Parameters:
- PATTERN_W, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101: pattern value. PATTERN[PATTERN_W-1] is the first bit received; PATTERN[0] is the last.
- OVERLAP, 1: 1 = overlapping detection (partial-match restart); 0 = restart from empty after each match.
- CNT_W, 8: width of the match counter. Used only with the optional feature.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous assert, active-low. 0 = in reset.
- in, input, 1: serial data bit, sampled every rising clk edge.
- out, output, 1: match flag. Combinational from the current state and `in` (Mealy).
- match_cnt, output, CNT_W: number of matches seen. Present only with MEALY_CNT_EN.

Behaviour:
- State encoding:
  - State k (0..PATTERN_W-1) = length of the longest pattern prefix that equals a suffix of the bits received so far.
  - State register is binary, ceil(log2(PATTERN_W)) bits wide.
- Reset:
  - rst=0 asynchronously forces the state to 0.
  - While rst=0, out is forced to 0 regardless of `in`.
  - Reset may assert at any time, including mid-pattern. All partial-match progress is discarded.
- Advance condition: in state k with k < PATTERN_W-1, if in == PATTERN[PATTERN_W-1-k], next state is k+1.
- Mismatch:
  - Next state is the longest prefix of the pattern that is a suffix of (received prefix of length k, followed by `in`).
  - This is the KMP fallback. Compute it at elaboration time with a constant function; do not hard-code it.
- Match condition: state PATTERN_W-1 and in == PATTERN[0].
  - out = 1 combinationally in that same cycle. There is no register delay; the pulse lasts one cycle per match.
  - OVERLAP=1: next state = length of the longest proper border of PATTERN.
  - OVERLAP=0: next state = 0.
- out = 0 in all other cases.
- Default 1101 transitions (S0..S3):
  - S0: 1→S1, 0→S0.
  - S1: 1→S2, 0→S0.
  - S2: 1→S2, 0→S3.
  - S3: 1→out=1, then S1 (OVERLAP=1) or S0 (OVERLAP=0); 0→S0.
- `in` must be stable around the clock edge. out may glitch between edges; consumers sample it on clk.
- The first clk edge after rst deasserts processes `in` normally.

Optional Feature:
- Macro: MEALY_CNT_EN.
- When defined:
  - Adds port match_cnt.
  - Counter increments on each rising edge where out=1.
  - Saturates at 2^CNT_W-1.
  - Asynchronously cleared to 0 when rst=0.
- When undefined: no counter logic and no match_cnt port. out behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 and toggle `in` for 3 cycles → out=0 throughout; state 0 after release.
- Basic stream: after reset, in = 0,1,1,0,1,1,1,0,1 one bit per cycle → out=1 only during bits 5 and 9; 0 elsewhere.
- Overlap: in = 1,1,0,1,1,0,1.
  - OVERLAP=1 → out=1 on bits 4 and 7.
  - OVERLAP=0 → out=1 on bit 4 only.
- Mid-pattern reset: in = 1,1,0, then rst=0 for one cycle, then in=1 → no match (out=0); then 1,1,0,1 → out=1 on the last bit.
- Mealy timing: hold state S3, then change `in` 0→1 between edges → out rises combinationally before the next edge.
- Counter (MEALY_CNT_EN, CNT_W=2): feed 1101 five times back-to-back → match_cnt = 1,2,3,3,3 (saturates); rst=0 → match_cnt=0.
